riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter: RD_LATENCY, 1, cache_rdata valid RD_LATENCY cycles after the posedge that samples cache_addr; legal range 1..4.
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports are clk and rst, listed next.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  1  memory request present.
REQ-006 SHALL have port: req_ready  output  1  LSU accepts request this cycle.
REQ-007 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port: req_funct3  input  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  32  store data, LSB-aligned.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  output  32  extended load data.
REQ-013 SHALL have port: resp_misalign  output  1  request rejected (misaligned or illegal funct3).
REQ-014 SHALL have port: cache_d_write_en  output  1  to data cache write enable.
REQ-015 SHALL have port: cache_d_write  output  `CACHE_D_WRITE_LEN  SW/SH/SB code from riscv_defs.v.
REQ-016 SHALL have port: cache_addr  output  32  to data cache addr.
REQ-017 SHALL have port: cache_wdata  output  32  to data cache data_to_cache, LSB-aligned, unshifted.
REQ-018 SHALL have port: cache_rdata  input  32  from data cache data_out, full word.

Function
REQ-019 SHALL implement states IDLE, WRITE, READ, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL latch we/funct3/addr/wdata on the req_valid&req_ready cycle; new requests are ignored outside IDLE.
REQ-021 SHALL flag misalign when: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >010.
REQ-022 SHALL route a misaligned request IDLE->RESP with resp_misalign=1, resp_rdata unchanged, and no cache write.
REQ-023 SHALL route an aligned store IDLE->WRITE(1 cycle)->RESP; cache_d_write_en=1 only in WRITE.
REQ-024 SHALL route an aligned load IDLE->READ (RD_LATENCY+1 cycles, 3-bit down-counter)->RESP.
REQ-025 SHALL sample cache_rdata on the last READ posedge.
REQ-026 SHALL drive cache_addr/cache_wdata/cache_d_write from latched values in WRITE and READ, and hold them otherwise; cache_d_write maps funct3[1:0] 10->SW, 01->SH, 00->SB.
REQ-027 SHALL extract load data as follows: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-028 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; resp_rdata/resp_misalign hold until the next RESP.
REQ-029 SHALL meet latency from the accept edge T: store resp_valid at T+2; load at T+2+RD_LATENCY; misaligned at T+1; back-to-back throughput is one request per latency+1 cycles.

Reset
REQ-030 SHALL on rst=1 immediately (asynchronously) enter IDLE and drive req_ready=1 (once rst low), resp_valid=0, resp_misalign=0, resp_rdata=0, cache_d_write_en=0, cache_addr=0, cache_wdata=0, cache_d_write=0.
REQ-031 SHALL abandon any operation in flight on mid-operation reset, with no response, and SHALL not hold write enable past the rst edge.

Verification
REQ-032 SHALL pass: SW addr 0x10 data 0xDEADBEEF -> write_en=1 at T+1 with SW code, cache_addr=0x10; resp_valid at T+2, misalign=0.
REQ-033 SHALL pass: LB addr 0x13, cache word 0x80FF1234, RD_LATENCY=1 -> resp_rdata=0xFFFFFF80 at T+3; LBU same -> 0x00000080.
REQ-034 SHALL pass: LH addr 0x22, word 0x8001ABCD -> 0xFFFF8001; LHU -> 0x00008001.
REQ-035 SHALL pass: LW addr 0x02 -> resp_valid, misalign=1 at T+1, no write_en, resp_rdata unchanged; SH addr 0x05 -> same, no write.
REQ-036 SHALL pass: rst asserted during WRITE -> write_en drops immediately, no resp_valid, req_ready=1 after release.
REQ-037 SHALL pass: req_valid held high continuously with RD_LATENCY=3 -> accepts only in IDLE, each LW resp at T+5.

Source files
------------

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RISC-V load/store unit between the pipeline and a fixed-latency data cache
//
// Purpose: accepts one load or store at a time, rejects misaligned or illegal
// requests, drives the data cache, and returns sign/zero-extended load data.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only while idle)
//   req_we, req_funct3            1=store/0=load, RISC-V size/sign code
//   req_addr, req_wdata           byte address, LSB-aligned store data
//   resp_valid                    one-cycle completion pulse
//   resp_rdata, resp_misalign     extended load data, rejection flag (held)
//   cache_d_write_en              cache write strobe
//   cache_d_write                 SW/SH/SB size code
//   cache_addr, cache_wdata       cache address and unshifted store data
//   cache_rdata                   full word returned by the cache

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`endif
`ifndef CACHE_D_SB
`define CACHE_D_SB 2'b01
`endif
`ifndef CACHE_D_SH
`define CACHE_D_SH 2'b10
`endif
`ifndef CACHE_D_SW
`define CACHE_D_SW 2'b11
`endif

module riscv_lsu #(
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [2:0]                    req_funct3,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    output logic                          resp_valid,
    output logic [31:0]                   resp_rdata,
    output logic                          resp_misalign,
    output logic                          cache_d_write_en,
    output logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write,
    output logic [31:0]                   cache_addr,
    output logic [31:0]                   cache_wdata,
    input  logic [31:0]                   cache_rdata
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    // READ lasts RD_LATENCY+1 cycles: the counter runs RD_LATENCY..0.
    localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

    state_t      state, state_n;
    logic [2:0]  rd_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        accept;
    logic        bad_req;
    logic        read_done;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [`CACHE_D_WRITE_LEN-1:0] size_code;

    assign accept    = req_valid && req_ready;
    assign read_done = (state == READ) && (rd_cnt == 3'd0);

    // Illegal funct3 for the direction, or address not aligned to access size.
    always_comb begin
        bad_req = 1'b0;
        if (req_we)
            bad_req = (req_funct3 > 3'b010);
        else
            bad_req = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        case (req_funct3[1:0])
            2'b01:   if (req_addr[0])            bad_req = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) bad_req = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b10:   size_code = `CACHE_D_SW;
            2'b01:   size_code = `CACHE_D_SH;
            default: size_code = `CACHE_D_SB;
        endcase
    end

    always_comb begin
        byte_sel = cache_rdata[{addr_lo_q, 3'b000} +: 8];
        half_sel = addr_lo_q[1] ? cache_rdata[31:16] : cache_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = cache_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept) state_n = bad_req ? RESP : (req_we ? WRITE : READ);
            WRITE: state_n = RESP;
            READ:  if (rd_cnt == 3'd0) state_n = RESP;
            RESP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready        = (state == IDLE) && !rst;
        cache_d_write_en = (state == WRITE);
        resp_valid       = (state == RESP);
    end

    // Datapath registers. Cache-facing values only change on an aligned
    // accept, so a rejected request leaves the cache bus untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt        <= 3'd0;
            funct3_q      <= 3'd0;
            addr_lo_q     <= 2'd0;
            cache_addr    <= 32'd0;
            cache_wdata   <= 32'd0;
            cache_d_write <= '0;
            resp_rdata    <= 32'd0;
            resp_misalign <= 1'b0;
        end else begin
            if (accept) begin
                rd_cnt    <= LAT_INIT;
                funct3_q  <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                if (bad_req) begin
                    resp_misalign <= 1'b1;
                end else begin
                    cache_addr    <= req_addr;
                    cache_wdata   <= req_wdata;
                    cache_d_write <= size_code;
                end
            end else if (state == READ) begin
                rd_cnt <= rd_cnt - 3'd1;
            end
            if (state == WRITE)
                resp_misalign <= 1'b0;
            if (read_done) begin
                resp_misalign <= 1'b0;
                resp_rdata    <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu at read latencies 1 and 3

module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_misalign [2];
    logic        cache_d_write_en [2];
    logic [1:0]  cache_d_write [2];
    logic [31:0] cache_addr [2];
    logic [31:0] cache_wdata [2];
    logic [31:0] cache_rdata [2];

    logic [31:0] mem_w [64];
    logic [31:0] last_rd [2];
    logic [31:0] last_caddr [2];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Instance 0 runs at RD_LATENCY=1, instance 1 at RD_LATENCY=3. The cache
    // model returns the word addressed RD_LATENCY cycles after it saw the address.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] pipe [4];
        riscv_lsu #(.RD_LATENCY(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we), .req_funct3(req_funct3),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
            .resp_misalign(resp_misalign[g]),
            .cache_d_write_en(cache_d_write_en[g]), .cache_d_write(cache_d_write[g]),
            .cache_addr(cache_addr[g]), .cache_wdata(cache_wdata[g]),
            .cache_rdata(cache_rdata[g])
        );
        always @(posedge clk) begin
            pipe[0] <= cache_addr[g];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign cache_rdata[g] = mem_w[pipe[LAT-1][7:2]];
    end

    function automatic int lat(input int idx);
        return (idx == 0) ? 1 : 3;
    endfunction

    function automatic bit ref_misalign(input bit we, input bit [2:0] f3, input bit [31:0] addr);
        int size_bytes;
        if (we && f3 > 2) return 1'b1;
        if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        size_bytes = 1 << (f3 % 4);
        return (addr % size_bytes) != 0;
    endfunction

    function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] word);
        bit [31:0] b, h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic bit [1:0] ref_code(input bit [2:0] f3);
        case (f3)
            3'd2:    return 2'b11;
            3'd1:    return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic do_req(input int idx, input bit we, input bit [2:0] f3,
                          input bit [31:0] addr, input bit [31:0] wdata);
        bit mis;
        int exp_cyc, resp_cyc, we_cnt;
        bit [31:0] exp_rd, exp_caddr;
        mis       = ref_misalign(we, f3, addr);
        exp_cyc   = mis ? 1 : (we ? 2 : 2 + lat(idx));
        exp_rd    = (mis || we) ? last_rd[idx] : ref_load(f3, addr, mem_w[addr[7:2]]);
        exp_caddr = mis ? last_caddr[idx] : addr;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid[idx] = 1'b1;
        total++;
        if (req_ready[idx] !== 1'b1) begin
            bad++; $display("FAIL ready_before_req dut%0d got=%b want=1", idx, req_ready[idx]);
        end
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        resp_cyc = 0; we_cnt = 0;
        for (int k = 1; k <= 12 && resp_cyc == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (cache_addr[idx] !== exp_caddr) begin
                    bad++; $display("FAIL cache_addr dut%0d got=%h want=%h", idx, cache_addr[idx], exp_caddr);
                end
            end
            if (cache_d_write_en[idx] === 1'b1) begin
                we_cnt++;
                total++;
                if (k != 1 || cache_wdata[idx] !== wdata || cache_d_write[idx] !== ref_code(f3)) begin
                    bad++;
                    $display("FAIL store_bus dut%0d cyc=%0d wdata=%h code=%b want cyc=1 wdata=%h code=%b",
                             idx, k, cache_wdata[idx], cache_d_write[idx], wdata, ref_code(f3));
                end
            end
            if (resp_valid[idx] === 1'b1) begin
                resp_cyc = k;
                total++;
                if (resp_misalign[idx] !== mis || resp_rdata[idx] !== exp_rd) begin
                    bad++;
                    $display("FAIL resp_data dut%0d f3=%0d addr=%h got mis=%b rd=%h want mis=%b rd=%h",
                             idx, f3, addr, resp_misalign[idx], resp_rdata[idx], mis, exp_rd);
                end
            end
        end
        total++;
        if (resp_cyc != exp_cyc) begin
            bad++; $display("FAIL resp_latency dut%0d got=%0d want=%0d", idx, resp_cyc, exp_cyc);
        end
        total++;
        if (we_cnt != ((we && !mis) ? 1 : 0)) begin
            bad++; $display("FAIL write_en_count dut%0d got=%0d want=%0d", idx, we_cnt, (we && !mis) ? 1 : 0);
        end
        @(negedge clk);
        total++;
        if (resp_valid[idx] !== 1'b0 || req_ready[idx] !== 1'b1) begin
            bad++; $display("FAIL resp_pulse dut%0d valid=%b ready=%b want valid=0 ready=1",
                            idx, resp_valid[idx], req_ready[idx]);
        end
        last_rd[idx]    = exp_rd;
        last_caddr[idx] = exp_caddr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (resp_valid[i] !== 1'b0 || resp_misalign[i] !== 1'b0 || resp_rdata[i] !== 32'd0 ||
                cache_d_write_en[i] !== 1'b0 || cache_addr[i] !== 32'd0 ||
                cache_wdata[i] !== 32'd0 || cache_d_write[i] !== 2'd0) begin
                bad++; $display("FAIL reset_outputs dut%0d valid=%b mis=%b rd=%h we=%b addr=%h wd=%h code=%b want all 0",
                                i, resp_valid[i], resp_misalign[i], resp_rdata[i], cache_d_write_en[i],
                                cache_addr[i], cache_wdata[i], cache_d_write[i]);
            end
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (req_ready[i] !== 1'b1) begin
                bad++; $display("FAIL reset_ready dut%0d got=%b want=1", i, req_ready[i]);
            end
            last_rd[i] = 32'd0; last_caddr[i] = 32'd0;
        end
    endtask

    task automatic test_store();
        do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        do_req(1, 1'b1, 3'd1, 32'h26, 32'h0000BEEF);
        do_req(1, 1'b1, 3'd0, 32'h33, 32'h000000A5);
    endtask

    task automatic test_load_ext();
        mem_w[4] = 32'h80FF1234;
        do_req(0, 1'b0, 3'd0, 32'h13, 32'h0);
        total++;
        if (resp_rdata[0] !== 32'hFFFFFF80) begin
            bad++; $display("FAIL lb_0x13 got=%h want=ffffff80", resp_rdata[0]);
        end
        do_req(0, 1'b0, 3'd4, 32'h13, 32'h0);
        total++;
        if (resp_rdata[0] !== 32'h00000080) begin
            bad++; $display("FAIL lbu_0x13 got=%h want=00000080", resp_rdata[0]);
        end
        mem_w[8] = 32'h8001ABCD;
        do_req(0, 1'b0, 3'd1, 32'h22, 32'h0);
        total++;
        if (resp_rdata[0] !== 32'hFFFF8001) begin
            bad++; $display("FAIL lh_0x22 got=%h want=ffff8001", resp_rdata[0]);
        end
        do_req(0, 1'b0, 3'd5, 32'h22, 32'h0);
        total++;
        if (resp_rdata[0] !== 32'h00008001) begin
            bad++; $display("FAIL lhu_0x22 got=%h want=00008001", resp_rdata[0]);
        end
        do_req(1, 1'b0, 3'd2, 32'h20, 32'h0);
    endtask

    task automatic test_misalign();
        do_req(0, 1'b0, 3'd2, 32'h02, 32'h0);
        do_req(0, 1'b1, 3'd1, 32'h05, 32'h12345678);
        do_req(1, 1'b0, 3'd3, 32'h08, 32'h0);
        do_req(1, 1'b1, 3'd4, 32'h0C, 32'h0);
        do_req(1, 1'b0, 3'd5, 32'h0B, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            mem_w[$urandom_range(0, 63)] = $urandom;
            do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        total++;
        if (cache_d_write_en[0] !== 1'b1) begin
            bad++; $display("FAIL mid_write_en_before got=%b want=1", cache_d_write_en[0]);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (cache_d_write_en[0] !== 1'b0 || cache_addr[0] !== 32'd0) begin
            bad++; $display("FAIL mid_reset_async we=%b addr=%h want we=0 addr=0", cache_d_write_en[0], cache_addr[0]);
        end
        repeat (2) @(negedge clk);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
                bad++; $display("FAIL mid_reset_after valid=%b ready=%b want valid=0 ready=1", resp_valid[0], req_ready[0]);
            end
        end
        for (int i = 0; i < 2; i++) begin last_rd[i] = 32'd0; last_caddr[i] = 32'd0; end
    endtask

    task automatic test_back_to_back();
        bit [31:0] a;
        bit [31:0] exp;
        req_we = 1'b0; req_funct3 = 3'd2;
        for (int n = 0; n < 5; n++) begin
            a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            mem_w[a[7:2]] = $urandom;
            exp = mem_w[a[7:2]];
            @(negedge clk);
            req_addr = a;
            req_valid[1] = 1'b1;
            total++;
            if (req_ready[1] !== 1'b1) begin
                bad++; $display("FAIL b2b_ready_idle n=%0d got=%b want=1", n, req_ready[1]);
            end
            @(posedge clk);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                total++;
                if (req_ready[1] !== 1'b0 || resp_valid[1] !== (k == 5)) begin
                    bad++; $display("FAIL b2b_busy n=%0d k=%0d ready=%b valid=%b want ready=0 valid=%b",
                                    n, k, req_ready[1], resp_valid[1], k == 5);
                end
                if (k == 5) begin
                    total++;
                    if (resp_rdata[1] !== exp || resp_misalign[1] !== 1'b0) begin
                        bad++; $display("FAIL b2b_data n=%0d got=%h mis=%b want=%h mis=0",
                                        n, resp_rdata[1], resp_misalign[1], exp);
                    end
                end
            end
        end
        #1 req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        last_rd[1] = exp; last_caddr[1] = a;
    endtask

    initial begin
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        for (int i = 0; i < 64; i++) mem_w[i] = $urandom;
        test_reset();
        test_store();
        test_load_ext();
        test_misalign();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
